// File: rtl/video_mnist_histogram_pkg.sv
// Shared register map and identity constant for the MNIST class histogram monitor.
package video_mnist_histogram_pkg;

    localparam int unsigned ADR_CORE_ID     = 32'h00;
    localparam int unsigned ADR_CTL         = 32'h01;
    localparam int unsigned ADR_STATUS      = 32'h02;
    localparam int unsigned ADR_IRQ_CLR     = 32'h03;
    localparam int unsigned ADR_FRAME_COUNT = 32'h04;
    localparam int unsigned ADR_PEAK        = 32'h05;
    localparam int unsigned ADR_RESULT_BASE = 32'h10;

    localparam logic [31:0] CORE_ID = 32'h4D48_0001;

endpackage

// File: rtl/video_mnist_histogram_counter.sv
// One class bin: saturating per-frame accumulator plus the snapshot register firmware reads.
module video_mnist_histogram_counter
    import video_mnist_histogram_pkg::*;
#(
    parameter int COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   wb_rst_i,
    input  logic                   hit_i,
    input  logic                   load_i,
    input  logic                   snap_i,
    output logic [COUNT_WIDTH-1:0] result_o
);

    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] res_q, res_d;

    // A load restarts the frame; the SOF pixel itself counts as the first hit.
    always_comb begin
        acc_d = acc_q;
        res_d = res_q;
        if (load_i) begin
            acc_d = hit_i ? COUNT_WIDTH'(1) : '0;
        end else if (hit_i && (acc_q != '1)) begin
            acc_d = acc_q + COUNT_WIDTH'(1);
        end
        if (snap_i) begin
            res_d = acc_q;
        end
    end

    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/video_mnist_class_histogram.sv
// Passive per-frame class histogram on the MNIST classification stream, read over Wishbone.
// Define VIDEO_MNIST_HISTOGRAM_PEAK_EN to add the post-snapshot argmax scan behind the PEAK register.
module video_mnist_class_histogram
    import video_mnist_histogram_pkg::*;
#(
    parameter int         NUM_CLASS    = 11,
    parameter int         NUMBER_WIDTH = 4,
    parameter int         TUSER_WIDTH  = 1,
    parameter int         COUNT_WIDTH  = 24,
    parameter int         WB_ADR_WIDTH = 8,
    parameter int         WB_DAT_WIDTH = 32,
    parameter int         WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter logic       INIT_ENABLE  = 1'b1
) (
    input  logic                    clk,
    input  logic                    wb_rst_i,
    input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
    input  logic                    s_axi4s_tlast,
    input  logic [NUMBER_WIDTH-1:0] s_axi4s_tnumber,
    input  logic                    s_axi4s_tvalid,
    input  logic                    s_axi4s_tready,
    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic                    s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_stb_i,
    output logic                    s_wb_ack_o,
    output logic                    irq
);

    localparam logic [NUMBER_WIDTH:0] NUM_CLASS_W = (NUMBER_WIDTH + 1)'(NUM_CLASS);

    logic                    beat, class_ok, load, snap, wr;
    logic [NUM_CLASS:0]      hit;
    logic [COUNT_WIDTH-1:0]  result [0:NUM_CLASS];
    logic                    en_q, en_d;
    logic                    sof_seen_q, sof_seen_d;
    logic                    irq_q, irq_d;
    logic [31:0]             frame_count_q, frame_count_d;
    logic [WB_DAT_WIDTH-1:0] rd_data, peak_word;
    logic                    unused_ok;

    assign beat     = s_axi4s_tvalid & s_axi4s_tready;
    assign class_ok = {1'b0, s_axi4s_tnumber} < NUM_CLASS_W;
    assign load     = beat & en_q & s_axi4s_tuser[0];
    assign snap     = load & sof_seen_q;
    assign wr       = s_wb_stb_i & s_wb_we_i;

    // Bin NUM_CLASS collects every out-of-range class index.
    for (genvar i = 0; i <= NUM_CLASS; i++) begin : g_bin
        if (i < NUM_CLASS) begin : g_class
            assign hit[i] = beat & en_q & class_ok & (s_axi4s_tnumber == NUMBER_WIDTH'(i));
        end else begin : g_invalid
            assign hit[i] = beat & en_q & ~class_ok;
        end
        video_mnist_histogram_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_counter (
            .clk      (clk),
            .wb_rst_i (wb_rst_i),
            .hit_i    (hit[i]),
            .load_i   (load),
            .snap_i   (snap),
            .result_o (result[i])
        );
    end

    always_comb begin
        en_d          = en_q;
        sof_seen_d    = sof_seen_q;
        irq_d         = irq_q;
        frame_count_d = frame_count_q;
        if (wr && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL))) begin
            en_d = s_wb_dat_i[0];
        end
        if (!en_q) begin
            sof_seen_d = 1'b0;
        end else if (load) begin
            sof_seen_d = 1'b1;
        end
        if (snap) begin
            irq_d         = 1'b1;
            frame_count_d = frame_count_q + 32'd1;
        end else if (wr && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_IRQ_CLR))) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            en_q          <= INIT_ENABLE;
            sof_seen_q    <= 1'b0;
            irq_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            en_q          <= en_d;
            sof_seen_q    <= sof_seen_d;
            irq_q         <= irq_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef VIDEO_MNIST_HISTOGRAM_PEAK_EN
    logic                   scan_busy_q, scan_busy_d;
    logic [7:0]             scan_idx_q, scan_idx_d;
    logic [7:0]             best_idx_q, best_idx_d;
    logic [7:0]             peak_q, peak_d;
    logic [COUNT_WIDTH-1:0] best_val_q, best_val_d;
    logic [COUNT_WIDTH-1:0] scan_val;
    logic                   better;

    always_comb begin
        scan_val = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (scan_idx_q == 8'(i)) scan_val = result[i];
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    assign better = (scan_idx_q == 8'd0) || (scan_val > best_val_q);

    always_comb begin
        scan_busy_d = scan_busy_q;
        scan_idx_d  = scan_idx_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        peak_d      = peak_q;
        if (snap) begin
            scan_busy_d = 1'b1;
            scan_idx_d  = 8'd0;
            best_idx_d  = 8'd0;
            best_val_d  = '0;
        end else if (scan_busy_q) begin
            if (better) begin
                best_idx_d = scan_idx_q;
                best_val_d = scan_val;
            end
            if (scan_idx_q == 8'(NUM_CLASS - 1)) begin
                scan_busy_d = 1'b0;
                peak_d      = better ? scan_idx_q : best_idx_q;
            end else begin
                scan_idx_d = scan_idx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            scan_busy_q <= 1'b0;
            scan_idx_q  <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            peak_q      <= '0;
        end else begin
            scan_busy_q <= scan_busy_d;
            scan_idx_q  <= scan_idx_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            peak_q      <= peak_d;
        end
    end

    always_comb begin
        peak_word                 = '0;
        peak_word[7:0]            = peak_q;
        peak_word[WB_DAT_WIDTH-1] = scan_busy_q;
    end
`else
    assign peak_word = '0;
`endif

    always_comb begin
        rd_data = '0;
        case (s_wb_adr_i)
            WB_ADR_WIDTH'(ADR_CORE_ID):     rd_data = WB_DAT_WIDTH'(CORE_ID);
            WB_ADR_WIDTH'(ADR_CTL):         rd_data = WB_DAT_WIDTH'(en_q);
            WB_ADR_WIDTH'(ADR_STATUS):      rd_data = WB_DAT_WIDTH'(irq_q);
            WB_ADR_WIDTH'(ADR_FRAME_COUNT): rd_data = WB_DAT_WIDTH'(frame_count_q);
            WB_ADR_WIDTH'(ADR_PEAK):        rd_data = peak_word;
            default: begin
                for (int i = 0; i <= NUM_CLASS; i++) begin
                    if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_RESULT_BASE + i)) begin
                        rd_data = WB_DAT_WIDTH'(result[i]);
                    end
                end
            end
        endcase
    end

    assign s_wb_dat_o = s_wb_stb_i ? rd_data : '0;
    assign s_wb_ack_o = s_wb_stb_i;
    assign irq        = irq_q;

    assign unused_ok = ^{s_axi4s_tlast, s_wb_sel_i, s_axi4s_tuser, s_wb_dat_i};

endmodule

// File: tb/tb_video_mnist_class_histogram.sv
// Randomised and directed checks of the class histogram against an array-based frame model.
module tb_video_mnist_class_histogram;

    localparam int NC   = 11;
    localparam int NW   = 4;
    localparam int CW   = 4;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          wb_rst_i = 1'b0;
    logic [0:0]    tuser = 1'b0;
    logic          tlast = 1'b0;
    logic [NW-1:0] tnumber = '0;
    logic          tvalid = 1'b0;
    logic          tready = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] dat_i = '0;
    logic [DW-1:0] dat_o;
    logic          we = 1'b0;
    logic [3:0]    sel = 4'hF;
    logic          stb = 1'b0;
    logic          ack;
    logic          irq;

    always #5 clk = ~clk;

    video_mnist_class_histogram #(
        .NUM_CLASS(NC), .NUMBER_WIDTH(NW), .TUSER_WIDTH(1), .COUNT_WIDTH(CW),
        .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(4), .INIT_ENABLE(1'b1)
    ) dut (
        .clk(clk), .wb_rst_i(wb_rst_i),
        .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast), .s_axi4s_tnumber(tnumber),
        .s_axi4s_tvalid(tvalid), .s_axi4s_tready(tready),
        .s_wb_adr_i(adr), .s_wb_dat_i(dat_i), .s_wb_dat_o(dat_o), .s_wb_we_i(we),
        .s_wb_sel_i(sel), .s_wb_stb_i(stb), .s_wb_ack_o(ack), .irq(irq)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          acc_m [0:NC];
    int          res_m [0:NC];
    logic [31:0] fc_m = '0;
    bit          irq_m = 0;
    bit          en_m = 1;
    bit          seen_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame-level model: what happened on this clock edge, given the inputs on the bus.
    task automatic model_step();
        int  c;
        bit  snap;
        snap = 0;
        if (en_m && tvalid && tready) begin
            c = (int'(tnumber) < NC) ? int'(tnumber) : NC;
            if (tuser[0]) begin
                if (seen_m) begin
                    for (int k = 0; k <= NC; k++) res_m[k] = acc_m[k];
                    fc_m = fc_m + 1;
                    snap = 1;
                end
                for (int k = 0; k <= NC; k++) acc_m[k] = 0;
                acc_m[c] = 1;
                seen_m = 1;
            end else if (acc_m[c] < MAXC) begin
                acc_m[c] = acc_m[c] + 1;
            end
        end
        if (!en_m) seen_m = 0;
        if (snap) irq_m = 1;
        else if (stb && we && adr == 8'h03) irq_m = 0;
        if (stb && we && adr == 8'h01) en_m = dat_i[0];
    endtask

    function automatic int peak_m();
        int best;
        best = 0;
        for (int k = 1; k < NC; k++) if (res_m[k] > res_m[best]) best = k;
        return best;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic beat(input int cls, input bit sof);
        tvalid = 1; tready = 1; tnumber = cls[NW-1:0]; tuser = sof;
        tick();
        tvalid = 0; tready = 0; tuser = 0;
    endtask

    task automatic wbw(input logic [7:0] a, input logic [31:0] d);
        adr = a; dat_i = d; stb = 1; we = 1;
        tick();
        stb = 0; we = 0;
    endtask

    task automatic rd(input logic [7:0] a, input string tag, input logic [31:0] exp);
        adr = a; stb = 1; we = 0;
        @(negedge clk);
        chk(tag, dat_o, exp);
        tick();
        stb = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_irq_pin"}, {31'b0, irq}, {31'b0, irq_m});
        rd(8'h00, {tag, "_core_id"}, 32'h4D48_0001);
        rd(8'h01, {tag, "_ctl"}, {31'b0, en_m});
        rd(8'h02, {tag, "_status"}, {31'b0, irq_m});
        rd(8'h04, {tag, "_frame_count"}, fc_m);
        for (int k = 0; k <= NC; k++) rd(8'(16 + k), $sformatf("%s_result%0d", tag, k), 32'(res_m[k]));
`ifdef VIDEO_MNIST_HISTOGRAM_PEAK_EN
        rd(8'h05, {tag, "_peak"}, 32'(peak_m()));
`else
        rd(8'h05, {tag, "_peak"}, 32'h0);
`endif
    endtask

    initial begin
        int fc_before;
        for (int k = 0; k <= NC; k++) begin acc_m[k] = 0; res_m[k] = 0; end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_dat_o", dat_o, 32'h0);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        adr = 8'h01; stb = 1;
        #1 chk("rst_ctl", dat_o, 32'h1);
        adr = 8'h10;
        #1 chk("rst_result0", dat_o, 32'h0);
        stb = 0;
        @(posedge clk); #1;
        wb_rst_i = 1;
        tick();
        check_all("reset");

        // Two-class frame then the closing SOF
        beat(3, 1);
        repeat (9) beat(3, 0);
        repeat (6) beat(7, 0);
        beat(0, 1);
        rd(8'h13, "t1_result3", 32'd10);
        rd(8'h17, "t1_result7", 32'd6);
        rd(8'h04, "t1_frame_count", 32'd1);
        rd(8'h02, "t1_status", 32'd1);
        check_all("t1");

        // Only handshaked cycles count
        tvalid = 1; tnumber = 4'd5;
        for (int i = 0; i < 8; i++) begin
            tready = (i % 2 == 0);
            tick();
        end
        tvalid = 0; tready = 0;
        beat(0, 1);
        rd(8'h15, "t2_result5", 32'd4);
        check_all("t2");

        // Saturation
        repeat (20) beat(0, 0);
        beat(1, 1);
        rd(8'h10, "t3_result0_sat", 32'd15);
        check_all("t3");

        // Out-of-range class goes to the invalid bin
        repeat (5) beat(12, 0);
        beat(0, 1);
        rd(8'h1B, "t4_invalid", 32'd5);
        check_all("t4");

        // Clear racing a snapshot loses; a lone clear wins
        adr = 8'h03; dat_i = 0; stb = 1; we = 1;
        tvalid = 1; tready = 1; tuser = 1; tnumber = 0;
        tick();
        stb = 0; we = 0; tvalid = 0; tready = 0; tuser = 0;
        rd(8'h02, "t5_status_set_wins", 32'd1);
        wbw(8'h03, 32'hFFFF_FFFF);
        rd(8'h02, "t5_status_cleared", 32'd0);
        chk("t5_irq_pin", {31'b0, irq}, 32'h0);

        // Disabled frame, then the first SOF after re-enable only clears
        fc_before = int'(fc_m);
        wbw(8'h01, 32'h0);
        beat(4, 1);
        repeat (5) beat(4, 0);
        beat(2, 1);
        wbw(8'h01, 32'h1);
        beat(6, 1);
        rd(8'h04, "t6_fc_unchanged", 32'(fc_before));
        repeat (3) beat(6, 0);
        beat(0, 1);
        rd(8'h04, "t6_fc_after", 32'(fc_before + 1));
        wbw(8'h04, 32'h55);
        rd(8'h06, "unmapped_06", 32'h0);
        rd(8'h1C, "unmapped_1c", 32'h0);
        check_all("t6");

`ifdef VIDEO_MNIST_HISTOGRAM_PEAK_EN
        beat(2, 1);
        repeat (8) beat(2, 0);
        repeat (9) beat(5, 0);
        beat(0, 1);
        adr = 8'h05; stb = 1; we = 0;
        @(negedge clk);
        chk("peak_busy", {31'b0, dat_o[31]}, 32'h1);
        tick();
        stb = 0;
        repeat (10) tick();
        rd(8'h05, "peak_tie_low", 32'd2);
`endif

        // Random frames
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(5, 40);
            beat($urandom_range(0, 15), 1);
            for (int i = 0; i < n; i++) begin
                tvalid  = ($urandom_range(0, 3) != 0);
                tready  = ($urandom_range(0, 3) != 0);
                tnumber = NW'($urandom_range(0, 15));
                tuser   = ($urandom_range(0, 40) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    adr = 8'h03; stb = 1; we = 1;
                end else if (f == 4 && $urandom_range(0, 9) == 0) begin
                    adr = 8'h01; dat_i = 32'($urandom_range(0, 1)); stb = 1; we = 1;
                end
                tick();
                stb = 0; we = 0; tvalid = 0; tready = 0; tuser = 0;
            end
            wbw(8'h01, 32'h1);
            beat($urandom_range(0, 15), 1);
            check_all($sformatf("rnd%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
